// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns one core load/store into one or two byte-enabled
// word accesses, then merges, extends and returns the load result.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byte_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         asm_q, asm_d;

  logic                req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0]         resp_rdata_d;
  logic                mem_read_d, mem_write_d;
  logic [3:0]          mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [31:0]         mem_wr_data_d;

  logic [2:0]          op_f3;
  logic [1:0]          op_off;
  logic [3:0]          size_mask;
  logic [7:0]          be_span;
  logic                split;

  function automatic logic illegal_op(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2] && f3[1]) || (we && (f3 >= 3'b011));
  endfunction

  // Right-justified store byte i goes to lane (off+i) mod 4 when that lane is enabled.
  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [3:0] be,
                                              input logic [1:0] off);
    logic [31:0] res;
    logic [31:0] sh;
    logic [1:0]  src;
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      src = 2'(k) - off;
      sh  = wd >> {src, 3'b000};
      if (be[k]) res[8*k +: 8] = sh[7:0];
    end
    return res;
  endfunction

  // Lane k of the read bus sits at the MSB end; it becomes result byte (k-off) mod 4.
  function automatic logic [31:0] capture(input logic [31:0] cur, input logic [31:0] rd,
                                          input logic [3:0] be, input logic [1:0] off);
    logic [31:0] res;
    logic [1:0]  dst;
    res = cur;
    for (int k = 0; k < LANES; k++) begin
      dst = 2'(k) - off;
      if (be[k]) res[{dst, 3'b000} +: 8] = rd[8*(LANES-1-k) +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return {{24{a[7]}}, a[7:0]};
      3'b001:  return {{16{a[15]}}, a[15:0]};
      3'b100:  return {24'b0, a[7:0]};
      3'b101:  return {16'b0, a[15:0]};
      default: return a;
    endcase
  endfunction

  // Operands of the access being set up: live request in IDLE, latched copy afterwards.
  always_comb begin
    op_f3  = (state_q == IDLE) ? req_funct3    : f3_q;
    op_off = (state_q == IDLE) ? req_addr[1:0] : addr_q[1:0];
    case (op_f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be_span = 8'(size_mask) << op_off;
    split   = |be_span[7:4];
  end

  // Next state, latched request fields and next value of every registered output.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    f3_d          = f3_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    asm_d         = asm_q;
    req_ready_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = '0;
    resp_err_d    = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_be_d      = '0;
    mem_addr_d    = '0;
    mem_wr_data_d = '0;

    if ((state_q == ACC1 || state_q == ACC2) && !we_q)
      asm_d = capture(asm_q, mem_rd_data, mem_byte_enable, addr_q[1:0]);

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          asm_d       = '0;
          req_ready_d = 1'b0;
          if (illegal_op(req_we, req_funct3)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d       = ACC1;
            mem_read_d    = !req_we;
            mem_write_d   = req_we;
            mem_be_d      = be_span[3:0];
            mem_addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wr_data_d = req_we ? store_lanes(req_wdata, be_span[3:0], op_off) : '0;
          end
        end
      end
      ACC1: begin
        if (split) begin
          state_d       = ACC2;
          mem_read_d    = !we_q;
          mem_write_d   = we_q;
          mem_be_d      = be_span[7:4];
          mem_addr_d    = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
          mem_wr_data_d = we_q ? store_lanes(wdata_q, be_span[7:4], op_off) : '0;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : extend(f3_q, asm_d);
        end
      end
      ACC2: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : extend(f3_q, asm_d);
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      f3_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      asm_q           <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_err        <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_addr        <= '0;
      mem_wr_data     <= '0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      f3_q            <= f3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      asm_q           <= asm_d;
      req_ready       <= req_ready_d;
      resp_valid      <= resp_valid_d;
      resp_rdata      <= resp_rdata_d;
      resp_err        <= resp_err_d;
      mem_read        <= mem_read_d;
      mem_write       <= mem_write_d;
      mem_byte_enable <= mem_be_d;
      mem_addr        <= mem_addr_d;
      mem_wr_data     <= mem_wr_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a byte-addressed reference memory predicts
// every word access and every response; a bus-side memory serves the DUT.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wd;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bus_mem [logic [31:0]];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        pend_we = 1'b0;
  logic [31:0] pend_addr, pend_data;
  logic [3:0]  pend_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'd0:    return 32'($signed(r[7:0]));
      3'd1:    return 32'($signed(r[15:0]));
      3'd4:    return 32'(r[7:0]);
      3'd5:    return 32'(r[15:0]);
      default: return r;
    endcase
  endfunction

  // Word as seen on mem_rd_data: byte offset 0 is the MSB byte.
  task automatic preload(input logic [31:0] wa, input logic [31:0] rdv);
    for (int k = 0; k < 4; k++) begin
      ref_mem[wa + 32'(k)] = rdv[31-8*k -: 8];
      bus_mem[wa + 32'(k)] = rdv[31-8*k -: 8];
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus memory commits a write at the edge that ends the access, unless reset is held.
  initial forever begin
    @(posedge clk);
    if (pend_we && rst_n)
      for (int k = 0; k < 4; k++)
        if (pend_be[k]) bus_mem[pend_addr + 32'(k)] = pend_data[8*k +: 8];
    pend_we = 1'b0;
  end

  // Monitor: serve reads, pop expected accesses/responses, flag missing ones.
  initial begin
    acc_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      mem_rd_data = mem_read ? {bus_byte(mem_addr), bus_byte(mem_addr + 32'd1),
                                bus_byte(mem_addr + 32'd2), bus_byte(mem_addr + 32'd3)}
                             : $urandom();
      if (mem_read || mem_write) begin
        check("ready_busy", 32'(req_ready), 32'd0);
        check("acc_pending", 32'(acc_q.size() > 0), 32'd1);
        if (acc_q.size() > 0) begin
          e = acc_q.pop_front();
          check("acc_addr", mem_addr, e.addr);
          check("acc_be", 32'(mem_byte_enable), 32'(e.be));
          check("acc_rw", 32'({mem_read, mem_write}), 32'({!e.we, e.we}));
          check("acc_cycle", 32'(cyc), 32'(e.cyc));
          if (e.we) check("acc_wdata", mem_wr_data, e.wd);
        end
        pend_we   = mem_write;
        pend_addr = mem_addr;
        pend_be   = mem_byte_enable;
        pend_data = mem_wr_data;
      end else begin
        check("idle_mem", mem_addr | mem_wr_data | 32'(mem_byte_enable), 32'd0);
      end
      if (resp_valid) begin
        check("rsp_pending", 32'(rsp_q.size() > 0), 32'd1);
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          check("rsp_rdata", resp_rdata, r.rdata);
          check("rsp_err", 32'(resp_err), 32'(r.err));
          check("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
      if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
        check("acc_timeout", 32'(cyc), 32'(acc_q[0].cyc - 1));
        void'(acc_q.pop_front());
      end
      if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        check("rsp_timeout", 32'(cyc), 32'(rsp_q[0].cyc - 1));
        void'(rsp_q.pop_front());
      end
    end
  end

  // Issue one request at a negedge with req_ready high; predict its accesses and response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit noise, input bit abort);
    int          acc0, size;
    bit          illegal, split;
    acc_t        a1, a2;
    rsp_t        r;
    logic [31:0] res, a, base;
    logic [1:0]  lane;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    acc0    = cyc;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd3);
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (illegal) begin
      r = '{32'd0, 1'b1, acc0 + 1};
      rsp_q.push_back(r);
    end else begin
      base  = {addr[31:2], 2'b00};
      a1    = '{base, 4'd0, we, 32'd0, acc0 + 1};
      a2    = '{base + 32'd4, 4'd0, we, 32'd0, acc0 + 2};
      split = 1'b0;
      res   = '0;
      for (int i = 0; i < size; i++) begin
        a    = addr + 32'(i);
        lane = a[1:0];
        if (a[31:2] == base[31:2]) begin
          a1.be[lane] = 1'b1;
          a1.wd[8*lane +: 8] = wd[8*i +: 8];
        end else begin
          split = 1'b1;
          a2.be[lane] = 1'b1;
          a2.wd[8*lane +: 8] = wd[8*i +: 8];
        end
        if (we) begin
          if (!(abort && a[31:2] != base[31:2])) ref_mem[a] = wd[8*i +: 8];
        end else begin
          res[8*i +: 8] = ref_byte(a);
        end
      end
      acc_q.push_back(a1);
      if (split) acc_q.push_back(a2);
      r = '{we ? 32'd0 : ext_model(f3, res), 1'b0, acc0 + (split ? 3 : 2)};
      if (!abort) rsp_q.push_back(r);
    end
    @(posedge clk);
    if (abort) begin
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_resp", {resp_rdata[30:0], resp_valid | resp_err}, 32'd0);
      check("abort_strobe", 32'({mem_read, mem_write}), 32'd0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (req_ready) break;
        if (noise) begin
          req_valid = 1'b1; req_we = 1'($urandom()); req_funct3 = 3'($urandom());
          req_addr = $urandom(); req_wdata = $urandom();
        end else begin
          req_valid = 1'b0;
        end
      end
      req_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", resp_rdata | 32'({resp_valid, resp_err}), 32'd0);
    check("rst_mem", mem_addr | mem_wr_data | 32'({mem_byte_enable, mem_read, mem_write}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned store, then aligned byte/half loads with extension.
    do_req(1'b1, 3'b010, 32'h2000_0008, 32'h1122_3344, 1'b0, 1'b0);
    preload(32'h2000_0008, 32'h4433_8211);
    do_req(1'b0, 3'b000, 32'h2000_0009, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 3'b000, 32'h2000_000A, 32'h0, 1'b0, 1'b0);
    preload(32'h2000_0008, 32'h1122_8344);
    do_req(1'b0, 3'b001, 32'h2000_000A, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 3'b101, 32'h2000_000A, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 3'b001, 32'h2000_0008, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 3'b100, 32'h2000_0008, 32'h0, 1'b0, 1'b0);

    // Split word load, split half store with read-back, wrapping split load.
    preload(32'h2000_0008, 32'h0000_8877);
    preload(32'h2000_000C, 32'h6655_AAAA);
    do_req(1'b0, 3'b010, 32'h2000_000A, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 3'b001, 32'h2000_0007, 32'h0000_BEEF, 1'b0, 1'b0);
    do_req(1'b0, 3'b001, 32'h2000_0007, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 3'b010, 32'h2000_0005, 32'h0, 1'b1, 1'b0);
    preload(32'hFFFF_FFFC, 32'h0102_8304);
    preload(32'h0000_0000, 32'hA5B6_C7D8);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 3'b010, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0);

    // Illegal encodings: no access, error response one cycle after accept.
    do_req(1'b0, 3'b011, 32'h2000_0008, 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 3'b100, 32'h2000_0008, 32'h1234_5678, 1'b0, 1'b0);
    do_req(1'b0, 3'b110, 32'h2000_0001, 32'h0, 1'b1, 1'b0);
    do_req(1'b1, 3'b111, 32'h2000_0002, 32'h0, 1'b0, 1'b0);

    // Random mix over a small window so loads see earlier stores.
    for (int n = 0; n < 48; n++)
      do_req(1'($urandom()), 3'($urandom()), 32'h4000_0000 + 32'($urandom_range(0, 31)),
             $urandom(), 1'($urandom()), 1'b0);

    // Split store aborted by reset in its second access, then read back.
    preload(32'h3000_0000, 32'h1111_1111);
    preload(32'h3000_0004, 32'h2222_2222);
    do_req(1'b1, 3'b010, 32'h3000_0002, 32'hA1B2_C3D4, 1'b0, 1'b1);
    do_req(1'b0, 3'b010, 32'h3000_0002, 32'h0, 1'b0, 1'b0);

    // Request presented while reset is held must not be accepted.
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2000_0008;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("rst_req_idle", 32'({mem_read, mem_write, resp_valid}), 32'd0);

    for (int i = 0; i < 10 && (acc_q.size() > 0 || rsp_q.size() > 0); i++) @(negedge clk);
    check("acc_q_drained", 32'(acc_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
